// File: rtl/sn74ls867.sv
// rtl/sn74ls867.sv - WIDTH-bit synchronous up/down presettable counter with async clear and cascadable enables
// Optional output delay modelling is enabled by defining SN74LS867_DELAY_EN.
module sn74ls867 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             s1,
    input  logic             s0,
    input  logic             enp_n,
    input  logic             ent_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco_n
);

    localparam logic [1:0]       MODE_HOLD = 2'b00;
    localparam logic [1:0]       MODE_DOWN = 2'b01;
    localparam logic [1:0]       MODE_LOAD = 2'b10;
    localparam logic [1:0]       MODE_UP   = 2'b11;
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [1:0]       mode;
    logic             count_en;
    logic             rco_n_d;

    assign mode     = {s1, s0};
    assign count_en = ~enp_n & ~ent_n;

    // Unknown mode select falls through to default and poisons the state.
    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_DOWN: if (count_en) q_d = q_q - ONE;
            MODE_LOAD: q_d = d;
            MODE_UP:   if (count_en) q_d = q_q + ONE;
            default:   q_d = {WIDTH{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= ALL_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal count is gated only by ent_n so a chain ripples through T enables.
    always_comb begin
        rco_n_d = 1'b1;
        if (!ent_n) begin
            if ((mode == MODE_UP) && (q_q == ALL_ONES)) begin
                rco_n_d = 1'b0;
            end
            if ((mode == MODE_DOWN) && (q_q == ALL_ZERO)) begin
                rco_n_d = 1'b0;
            end
        end
    end

`ifdef SN74LS867_DELAY_EN
    logic [WIDTH-1:0] q_clk_dly;
    logic             clr_dly;
    logic             rco_n_dly;

    assign #18 q_clk_dly = q_q;
    assign #25 clr_dly   = clr;
    assign #20 rco_n_dly = rco_n_d;

    assign q     = clr_dly ? q_clk_dly : ALL_ZERO;
    assign rco_n = rco_n_dly;
`else
    assign q     = q_q;
    assign rco_n = rco_n_d;
`endif

endmodule

// File: tb/tb_sn74ls867.sv
// tb/tb_sn74ls867.sv - directed self-checking bench for sn74ls867 including a two-stage cascade
module tb_sn74ls867;

    logic       clk_gen = 1'b0;
    logic       clk_x   = 1'b0;
    logic       clk;
    logic       clr     = 1'b0;
    logic       s1      = 1'b1;
    logic       s0      = 1'b1;
    logic       enp_n   = 1'b0;
    logic       ent_drv = 1'b0;
    logic       casc    = 1'b0;
    logic       ent_n;
    logic [7:0] d       = 8'h00;
    logic [7:0] q;
    logic       rco_n;
    logic [3:0] up_q;
    logic       up_rco_n;

    int passed = 0;
    int total  = 0;

    always #60 clk_gen = ~clk_gen;
    assign clk   = clk_x ? 1'bx : clk_gen;
    assign ent_n = casc ? up_rco_n : ent_drv;

    sn74ls867 #(.WIDTH(4)) u_up (
        .clk   (clk),
        .clr   (clr),
        .s1    (1'b1),
        .s0    (1'b1),
        .enp_n (1'b0),
        .ent_n (1'b0),
        .d     (4'h0),
        .q     (up_q),
        .rco_n (up_rco_n)
    );

    sn74ls867 #(.WIDTH(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .s1    (s1),
        .s0    (s0),
        .enp_n (enp_n),
        .ent_n (ent_n),
        .d     (d),
        .q     (q),
        .rco_n (rco_n)
    );

    task automatic tick();
        @(posedge clk_gen);
        @(negedge clk_gen);
    endtask

    task automatic load(input logic [7:0] val);
        s1 = 1'b1; s0 = 1'b0; d = val;
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b0; s1 = 1'b1; s0 = 1'b1; enp_n = 1'b0; ent_drv = 1'b0;
        tick();
        total++; if (q !== 8'h00) $display("FAIL reset_q0: got %h expected 00", q); else passed++;
        clk_x = 1'b1;
        #130;
        clk_x = 1'b0;
        tick();
        total++; if (q !== 8'h00) $display("FAIL reset_q_clkx: got %h expected 00", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL reset_rco_up: got %b expected 1", rco_n); else passed++;
        s0 = 1'b1; s1 = 1'b0;
        #25;
        total++; if (rco_n !== 1'b0) $display("FAIL reset_rco_down: got %b expected 0", rco_n); else passed++;
        s1 = 1'b1;
        #5 clr = 1'b1;
        tick();
        total++; if (q !== 8'h01) $display("FAIL reset_first_count: got %h expected 01", q); else passed++;
    endtask

    task automatic test_load_count();
        load(8'hFD);
        total++; if (q !== 8'hFD) $display("FAIL load_fd: got %h expected fd", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL load_rco: got %b expected 1", rco_n); else passed++;
        s1 = 1'b1; s0 = 1'b1;
        tick();
        total++; if (q !== 8'hFE) $display("FAIL up_fe: got %h expected fe", q); else passed++;
        tick();
        total++; if (q !== 8'hFF) $display("FAIL up_ff: got %h expected ff", q); else passed++;
        total++; if (rco_n !== 1'b0) $display("FAIL up_carry: got %b expected 0", rco_n); else passed++;
        tick();
        total++; if (q !== 8'h00) $display("FAIL up_wrap: got %h expected 00", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL up_carry_clear: got %b expected 1", rco_n); else passed++;
    endtask

    task automatic test_down();
        load(8'h02);
        s1 = 1'b0; s0 = 1'b1;
        tick();
        total++; if (q !== 8'h01) $display("FAIL down_01: got %h expected 01", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL down_rco_01: got %b expected 1", rco_n); else passed++;
        tick();
        total++; if (q !== 8'h00) $display("FAIL down_00: got %h expected 00", q); else passed++;
        total++; if (rco_n !== 1'b0) $display("FAIL down_borrow: got %b expected 0", rco_n); else passed++;
        tick();
        total++; if (q !== 8'hFF) $display("FAIL down_wrap: got %h expected ff", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL down_borrow_clear: got %b expected 1", rco_n); else passed++;
    endtask

    task automatic test_enable();
        load(8'hFF);
        s1 = 1'b1; s0 = 1'b1; enp_n = 1'b1; ent_drv = 1'b0;
        tick();
        total++; if (q !== 8'hFF) $display("FAIL enp_hold: got %h expected ff", q); else passed++;
        total++; if (rco_n !== 1'b0) $display("FAIL enp_rco: got %b expected 0", rco_n); else passed++;
        enp_n = 1'b0; ent_drv = 1'b1;
        tick();
        total++; if (q !== 8'hFF) $display("FAIL ent_hold: got %h expected ff", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL ent_rco: got %b expected 1", rco_n); else passed++;
        enp_n = 1'b1; ent_drv = 1'b1;
        load(8'h5A);
        total++; if (q !== 8'h5A) $display("FAIL load_disabled: got %h expected 5a", q); else passed++;
        enp_n = 1'b0; ent_drv = 1'b0; s1 = 1'b0; s0 = 1'b0;
        tick();
        total++; if (q !== 8'h5A) $display("FAIL hold_mode: got %h expected 5a", q); else passed++;
        total++; if (rco_n !== 1'b1) $display("FAIL hold_rco: got %b expected 1", rco_n); else passed++;
    endtask

    task automatic test_async_clear();
        load(8'h7F);
        s1 = 1'b1; s0 = 1'b1; enp_n = 1'b0; ent_drv = 1'b0;
        clr = 1'b0;
        #30;
        total++; if (q !== 8'h00) $display("FAIL async_clear: got %h expected 00", q); else passed++;
        #5 clr = 1'b1;
        tick();
        total++; if (q !== 8'h01) $display("FAIL resume_after_clear: got %h expected 01", q); else passed++;
    endtask

    task automatic test_cascade();
        clr = 1'b0; casc = 1'b1; s1 = 1'b1; s0 = 1'b1; enp_n = 1'b0;
        #30 clr = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        total++; if (q !== 8'h00) $display("FAIL casc_15_q: got %h expected 00", q); else passed++;
        total++; if (up_rco_n !== 1'b0) $display("FAIL casc_15_up_rco: got %b expected 0", up_rco_n); else passed++;
        tick();
        total++; if (q !== 8'h01) $display("FAIL casc_16_q: got %h expected 01", q); else passed++;
        total++; if (up_q !== 4'h0) $display("FAIL casc_16_up_q: got %h expected 0", up_q); else passed++;
        for (int i = 0; i < 16; i++) tick();
        total++; if (q !== 8'h02) $display("FAIL casc_32_q: got %h expected 02", q); else passed++;
        casc = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_count();
        test_down();
        test_enable();
        test_async_clear();
        test_cascade();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sn74ls867.md
# sn74ls867

Synchronous WIDTH-bit up/down presettable counter with an asynchronous clear and cascadable enables. It takes the upstream 4-bit binary counter's terminal count on its enable inputs, so it extends that counter into a wider synchronous chain. It can also run standalone as a loadable timer. The pin behaviour follows the 74AS867 family with a dedicated clear pin, and it is modelled for simulation alongside the other TTL devices.

## Interface
- WIDTH, 8, counter width in bits; supported range 4..16.

- clk  in  1  count clock; active on rising edge.
- clr  in  1  asynchronous clear, active-low; forces q to 0.
- s1, s0  in  1 each  mode select: 00 hold, 01 count down, 10 parallel load, 11 count up.
- enp_n  in  1  count enable P, active-low; not forwarded to rco_n.
- ent_n  in  1  count enable T, active-low; gates both counting and rco_n.
- d  in  WIDTH  parallel load data.
- q  out  WIDTH  counter state.
- rco_n  out  1  ripple carry/borrow out, active-low; feeds the next stage's ent_n.

## Operation
- Clock is clk; reset is asynchronous and active-low on clr.
- While clr=0:
  - q=0 immediately.
  - clk edges are ignored.
- While clr=1, on each rising clk edge, mode {s1,s0} selects the action:
  - 00: q holds.
  - 10: q<=d, regardless of enp_n and ent_n.
  - 11: if enp_n=0 and ent_n=0, q<=q+1 mod 2^WIDTH; otherwise q holds.
  - 01: if enp_n=0 and ent_n=0, q<=q-1 mod 2^WIDTH; otherwise q holds.
- Wrap-around:
  - Up mode from all-ones goes to 0.
  - Down mode from 0 goes to all-ones.
  - No sticky flag.
- rco_n is combinational. It is 0 if and only if ent_n=0 and either:
  - mode=11 and q is all-ones, or
  - mode=01 and q=0.
  It is 1 in all other cases, including load and hold.
- rco_n does not depend on enp_n.
- Cascading: the upstream stage's terminal-count output drives ent_n. The whole chain shares clk.
- x/z on s1/s0 while clr=1 and a clk edge occurs: q<=x (all bits).
- x on clk while clr=0: no effect.

## Timing
- Reset value: q=0. rco_n then follows its formula, e.g. mode=01 with ent_n=0 gives rco_n=0.
- Latency:
  - q updates on the rising clk edge.
  - rco_n follows q, mode and ent_n combinationally.
- Clear assertion overrides any edge in progress.
- Clear released in the same time step as a rising clk edge: clr is treated as still low, that edge is ignored, and the first count happens on the next edge.
- Mode or enables changing on the clock edge use the pre-edge values (standard setup semantics).
- Clear mid-count, for example at q=8'h7F: q=0 without waiting for clk, and counting resumes from 0.

## Configuration
- SN74LS867_DELAY_EN defined:
  - clk rising edge to q: 18 ns.
  - clr falling edge to q: 25 ns.
  - any input to rco_n: 20 ns.
  - Modelled as inertial delays.
- Undefined: all outputs switch with zero delay.
- Cycle behaviour is identical either way. The bench uses 60 ns phases so that both variants pass the same checks.

## Test plan
- Clear: clr=0 with clk toggling (including x), mode 11, enables 0 -> q=8'h00 throughout; clr=1, one edge -> q=8'h01.
- Load and count: mode 10 with d=8'hFD, one edge -> q=FD; mode 11, edges -> FE, then FF with rco_n=0, then 00 with rco_n=1.
- Down and borrow: load 8'h02, then mode 01 -> 01, then 00 with rco_n=0, then FF.
- Enable gating:
  - enp_n=1 with ent_n=0 at q=FF in up mode -> q holds at FF and rco_n=0.
  - ent_n=1 -> q holds and rco_n=1.
  - Load still works with both enables at 1.
- Async clear mid-count: q=8'h7F, drop clr between edges -> q=00 before the next edge.
- Cascade: chain this block's ent_n to the upstream 4-bit counter's carry. After 16 upstream clocks this block reads 01; after 32 it reads 02.
